// File: rtl/store_lane_packer.sv
// Store lane packer: narrows sb/sh/sw operands into word-aligned memory writes with byte enables,
// buffered in a small valid/ready FIFO; misaligned or reserved stores are dropped and reported.
module store_lane_packer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_wdata,
  output logic [3:0]       out_be,
  output logic             err_valid,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  function automatic logic [3:0] pack_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] pack_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      2'd0:    wd = {4{data[7:0]}};
      2'd1:    wd = {2{data[15:0]}};
      2'd2:    wd = data;
      default: wd = 32'h0000_0000;
    endcase
    return wd;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = lo[0];
      2'd2:    bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               err_valid_r;
  logic [31:0]        err_addr_r;
  logic [CNT_W-1:0]   err_count_r;

  logic               accept_s;
  logic               bad_s;
  logic               push_s;
  logic               pop_s;
  entry_t             new_entry_s;
  entry_t             head_s;

  // in_ready depends only on the occupancy register, never on in_valid
  assign in_ready  = (count_r != CW'(DEPTH));
  assign out_valid = (count_r != CW'(0));
  assign accept_s  = in_valid & in_ready;
  assign bad_s     = is_misaligned(in_size, in_addr[1:0]);
  assign push_s    = accept_s & ~bad_s;
  assign pop_s     = out_valid & out_ready;

  assign out_addr  = {head_s.waddr, 2'b00};
  assign out_wdata = head_s.wdata;
  assign out_be    = head_s.be;
  assign err_valid = err_valid_r;
  assign err_addr  = err_addr_r;
  assign err_count = err_count_r;

  // Pack the incoming request and select the head entry (zeros while empty)
  always_comb begin
    new_entry_s.waddr = in_addr[31:2];
    new_entry_s.wdata = pack_wdata(in_size, in_data);
    new_entry_s.be    = pack_be(in_size, in_addr[1:0]);
    if (out_valid) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= new_entry_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Dropped-store reporting: one-cycle pulse, last address, saturating count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_r <= 1'b0;
      err_addr_r  <= 32'h0000_0000;
      err_count_r <= {CNT_W{1'b0}};
    end else begin
      err_valid_r <= accept_s & bad_s;
      if (accept_s & bad_s) begin
        err_addr_r <= in_addr;
        if (err_count_r != {CNT_W{1'b1}}) begin
          err_count_r <= err_count_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_store_lane_packer.sv
// Scoreboard bench for store_lane_packer: directed stores push hand-computed expectations,
// a negedge monitor pops and compares on every memory-side pop and every error pulse.
module tb_store_lane_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_data;
  logic [1:0]  in_size;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_be;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  store_lane_packer #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_wdata(out_wdata), .out_be(out_be),
    .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  cnt;
  } err_t;

  exp_t       exp_q[$];
  err_t       err_q[$];
  exp_t       mon_e;
  err_t       mon_r;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one store; expectation is queued at the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                      input logic bad, input logic [3:0] be, input logic [31:0] wd);
    int   budget;
    exp_t e;
    err_t r;
    budget = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = sz;
    while (!in_ready && budget < 50) begin
      step(1);
      budget++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout addr=0x%08h: in_ready got 0 required 1", a);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (bad) begin
        exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
        r.addr = a;
        r.cnt  = exp_cnt;
        err_q.push_back(r);
      end else begin
        e.addr  = a & 32'hFFFF_FFFC;
        e.wdata = wd;
        e.be    = be;
        exp_q.push_back(e);
      end
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Monitor: compare every pop and every error pulse against the scoreboard
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got addr 0x%08h required no entry", out_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_addr", out_addr, mon_e.addr);
        check("pop_wdata", out_wdata, mon_e.wdata);
        check("pop_be", {28'd0, out_be}, {28'd0, mon_e.be});
      end
    end
    if (reset_n && err_valid) begin
      if (err_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_err: got err_addr 0x%08h required no error", err_addr);
      end else begin
        mon_r = err_q.pop_front();
        check("err_addr", err_addr, mon_r.addr);
        check("err_count", {24'd0, err_count}, {24'd0, mon_r.cnt});
      end
    end
  end

  initial begin
    int k;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_addr   = 32'd0;
    in_data   = 32'd0;
    in_size   = 2'd0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_wdata", out_wdata, 32'd0);
    check("rst_out_be", {28'd0, out_be}, 32'd0);
    #10 reset_n = 1'b1;
    step(1);

    // sb to lane 3, visible one cycle after accept while out_ready is low
    send(32'h0000_1003, 32'hABCD_EF12, 2'd0, 1'b0, 4'b1000, 32'h1212_1212);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_addr", out_addr, 32'h0000_1000);
    out_ready = 1'b1;
    step(1);

    // sh upper half, popped at the next edge
    send(32'h0000_2002, 32'h0000_BEEF, 2'd1, 1'b0, 4'b1100, 32'hBEEF_BEEF);
    check("t2_visible", {31'd0, out_valid}, 32'd1);
    step(1);
    check("t2_popped", {31'd0, out_valid}, 32'd0);

    // lane/size table
    send(32'h0000_1000, 32'h0000_00A5, 2'd0, 1'b0, 4'b0001, 32'hA5A5_A5A5);
    send(32'h0000_1001, 32'h0000_003C, 2'd0, 1'b0, 4'b0010, 32'h3C3C_3C3C);
    send(32'h0000_1002, 32'hFFFF_FF7E, 2'd0, 1'b0, 4'b0100, 32'h7E7E_7E7E);
    send(32'h0000_2000, 32'h1234_5678, 2'd1, 1'b0, 4'b0011, 32'h5678_5678);
    send(32'h0000_3004, 32'hDEAD_BEEF, 2'd2, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    step(2);

    // misaligned sw: dropped, one-cycle error pulse
    send(32'h0000_3001, 32'h5555_5555, 2'd2, 1'b1, 4'b0000, 32'd0);
    check("t3_err_pulse", {31'd0, err_valid}, 32'd1);
    check("t3_no_out", {31'd0, out_valid}, 32'd0);
    step(1);
    check("t3_err_done", {31'd0, err_valid}, 32'd0);

    // back-to-back errors: odd sh then reserved size
    send(32'h0000_4001, 32'h0000_1111, 2'd1, 1'b1, 4'b0000, 32'd0);
    check("b2b_err_first", {31'd0, err_valid}, 32'd1);
    send(32'h0000_4010, 32'h0000_2222, 2'd3, 1'b1, 4'b0000, 32'd0);
    check("b2b_err_second", {31'd0, err_valid}, 32'd1);
    step(1);
    check("b2b_err_done", {31'd0, err_valid}, 32'd0);

    // fill with out_ready low, head held stable, then release keeps order
    out_ready = 1'b0;
    step(1);
    send(32'h0000_5000, 32'h1111_1111, 2'd2, 1'b0, 4'b1111, 32'h1111_1111);
    send(32'h0000_5004, 32'h2222_2222, 2'd2, 1'b0, 4'b1111, 32'h2222_2222);
    check("t4_full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("t4_hold_addr", out_addr, 32'h0000_5000);
      check("t4_hold_wdata", out_wdata, 32'h1111_1111);
    end
    out_ready = 1'b1;
    send(32'h0000_5008, 32'h3333_3333, 2'd2, 1'b0, 4'b1111, 32'h3333_3333);
    step(3);
    check("t4_drained", {31'd0, out_valid}, 32'd0);

    // steady push+pop at occupancy 1: head is always the newest entry
    for (int i = 0; i < 11; i++) begin
      send(32'h0000_6000 + 32'(4 * i), 32'h0101_0101 * 32'(i), 2'd2, 1'b0, 4'b1111,
           32'h0101_0101 * 32'(i));
      if (i > 0) begin
        check("t5_out_valid", {31'd0, out_valid}, 32'd1);
        check("t5_head_addr", out_addr, 32'h0000_6000 + 32'(4 * i));
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
      end
    end
    step(2);

    // async reset with two entries queued
    out_ready = 1'b0;
    send(32'h0000_7000, 32'h7777_0000, 2'd2, 1'b0, 4'b1111, 32'h7777_0000);
    send(32'h0000_7004, 32'h7777_0004, 2'd2, 1'b0, 4'b1111, 32'h7777_0004);
    #2 reset_n = 1'b0;
    #1;
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_err_count", {24'd0, err_count}, 32'd0);
    check("t6_out_addr", out_addr, 32'd0);
    exp_q.delete();
    err_q.delete();
    exp_cnt = 8'd0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(1);
    check("t6_still_empty", {31'd0, out_valid}, 32'd0);

    // post-reset sanity: packing and error count restart
    out_ready = 1'b1;
    send(32'h0000_8002, 32'h0000_0099, 2'd0, 1'b0, 4'b0100, 32'h9999_9999);
    send(32'h0000_8001, 32'h0000_0000, 2'd2, 1'b1, 4'b0000, 32'd0);
    k = 0;
    while ((out_valid || err_valid) && k < 20) begin
      step(1);
      k++;
    end
    step(1);
    check("scoreboard_empty", 32'(exp_q.size() + err_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
